// File: rtl/nic_pkg.sv
// Shared constants for the processor-to-mesh network interface controller:
// register map, packet width and the position of the virtual-channel bit.
package nic_pkg;

  localparam int DATA_WIDTH = 64;

  // Memory-mapped register select values seen on the processor address bus.
  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Bit of each packet that carries its virtual channel.
  localparam int VC_BIT = 0;

endpackage

// File: rtl/cpu_nic_if.sv
// Bundles the processor register port and both router handshake directions.
// The slave modport is the NIC's view; the master modport is the view of the
// environment around it (processor plus router port).
interface cpu_nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);

  // Processor register access.
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;

  // Outgoing packets towards the router.
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;

  // Incoming packets from the router.
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_ro, net_polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_ro, net_polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );

endinterface

// File: rtl/nic_channel_buffer.sv
// Single-entry packet buffer with a full flag. A load captures data and sets
// the flag; a clear only drops the flag, so the stale payload stays readable.
// The parent guarantees load is only raised while empty and clear only while
// full, so the two strobes never coincide in practice; load still wins.
module nic_channel_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  full_q;
  logic                  full_d;

  // Next value of the full flag from the load/clear strobes.
  always_comb begin
    full_d = full_q;
    if (load_i) begin
      full_d = 1'b1;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  // Payload and flag registers; reset empties the slot and zeroes the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/cpu_nic.sv
// Network interface controller between the processor data-memory port and
// the local mesh router port. Holds one outgoing and one incoming packet,
// exposes them through four memory-mapped registers, and exchanges packets
// with the router using valid/ready gated by the router's VC polarity.
module cpu_nic #(
  parameter int DATA_WIDTH = nic_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  cpu_nic_if.slave  bus
);

  import nic_pkg::*;

  logic [ADDR_WIDTH-1:0] reg_sel;
  logic                  rd_en;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] in_buf;
  logic                  in_full;
  logic                  in_load;
  logic                  in_clr;

  logic [DATA_WIDTH-1:0] out_buf;
  logic                  out_full;
  logic                  out_load;
  logic                  out_clr;

  logic                  net_so;
  logic                  net_ri;

  logic [DATA_WIDTH-1:0] d_out_q;
  logic [DATA_WIDTH-1:0] d_out_d;

  assign reg_sel = bus.addr;
  assign rd_en   = bus.nicEn & ~bus.nicWrEn;
  assign wr_en   = bus.nicEn &  bus.nicWrEn;

  // Router handshake. Both valids/readies depend only on registered state
  // (plus polarity for the outgoing side), never on the peer's reply.
  assign net_so = out_full & (out_buf[VC_BIT] == bus.net_polarity);
  assign net_ri = ~in_full;

  // Incoming: capture while empty; a read of the buffer register frees the
  // slot only if it actually holds a packet, so an empty read has no effect.
  assign in_load = bus.net_si & net_ri;
  assign in_clr  = rd_en & (reg_sel == NIC_IN_BUF) & in_full;

  // Outgoing: a processor write is accepted only into an empty slot; a write
  // that races a completing transfer sees the slot still full and is dropped.
  assign out_load = wr_en & (reg_sel == NIC_OUT_BUF) & ~out_full;
  assign out_clr  = net_so & bus.net_ro;

  nic_channel_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_in_buf (
    .clk    (clk),
    .reset  (reset),
    .load_i (in_load),
    .clr_i  (in_clr),
    .data_i (bus.net_di),
    .data_o (in_buf),
    .full_o (in_full)
  );

  nic_channel_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk    (clk),
    .reset  (reset),
    .load_i (out_load),
    .clr_i  (out_clr),
    .data_i (bus.d_in),
    .data_o (out_buf),
    .full_o (out_full)
  );

  // Read-data mux; status flags sit in the top bit, idle cycles return zero.
  always_comb begin
    d_out_d = '0;
    if (rd_en) begin
      case (reg_sel)
        NIC_IN_BUF:   d_out_d = in_buf;
        NIC_IN_STAT:  d_out_d = {in_full,  {(DATA_WIDTH-1){1'b0}}};
        NIC_OUT_STAT: d_out_d = {out_full, {(DATA_WIDTH-1){1'b0}}};
        default:      d_out_d = '0;
      endcase
    end
  end

  // Registered read data, presented the cycle after the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign bus.d_out  = d_out_q;
  assign bus.net_so = net_so;
  assign bus.net_ri = net_ri;
  assign bus.net_do = out_buf;

endmodule

// File: tb/tb_cpu_nic.sv
// Self-checking bench for cpu_nic: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model of the NIC.
module tb_cpu_nic;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_nic_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) bus ();

  cpu_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: two slots with flags and the pending read result.
  bit          pol;
  bit          m_in_full;
  bit          m_out_full;
  logic [63:0] m_in_buf;
  logic [63:0] m_out_buf;
  logic [63:0] m_dout;

  // Values observed during the most recent cycle.
  logic [63:0] obs_dout;
  logic        obs_so;
  logic        obs_ri;
  logic [63:0] sent_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [1:0] a);
    case (a)
      2'b00:   return m_in_buf;
      2'b01:   return {m_in_full, 63'b0};
      2'b11:   return {m_out_full, 63'b0};
      default: return 64'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_in_full  = 1'b0;
    m_out_full = 1'b0;
    m_in_buf   = '0;
    m_out_buf  = '0;
    m_dout     = '0;
  endtask

  // One clock cycle: check registered read data, apply inputs, check the
  // combinational handshake outputs, then advance the model past the edge.
  task automatic cycle(input bit rst, input bit en, input bit we, input logic [1:0] a,
                       input logic [63:0] din, input bit ro, input bit si,
                       input logic [63:0] di);
    bit exp_so, exp_ri, send, cap;
    @(negedge clk);
    obs_dout = bus.d_out;
    chk("d_out", bus.d_out, m_dout);
    reset            = rst;
    bus.nicEn        = en;
    bus.nicWrEn      = we;
    bus.addr         = a;
    bus.d_in         = din;
    bus.net_ro       = ro;
    bus.net_si       = si;
    bus.net_di       = di;
    bus.net_polarity = pol;
    #1;
    exp_so = m_out_full && (m_out_buf[0] == pol);
    exp_ri = !m_in_full;
    obs_so = bus.net_so;
    obs_ri = bus.net_ri;
    chk("net_so", {63'b0, bus.net_so}, {63'b0, exp_so});
    chk("net_ri", {63'b0, bus.net_ri}, {63'b0, exp_ri});
    chk("net_do", bus.net_do, m_out_buf);
    if (rst) begin
      model_reset();
    end else begin
      send   = exp_so && ro;
      cap    = si && exp_ri;
      if (send) sent_q.push_back(m_out_buf);
      m_dout = (en && !we) ? ref_read(a) : 64'b0;
      if (en && !we && a == 2'b00) m_in_full = 1'b0;
      if (cap) begin
        m_in_buf  = di;
        m_in_full = 1'b1;
      end
      if (en && we && a == 2'b10 && !m_out_full) begin
        m_out_buf  = din;
        m_out_full = 1'b1;
      end else if (send) begin
        m_out_full = 1'b0;
      end
    end
    pol = ~pol;
  endtask

  task automatic idle(input bit ro = 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 64'b0, ro, 1'b0, 64'b0);
  endtask

  task automatic rd(input logic [1:0] a, input bit ro = 1'b0);
    cycle(1'b0, 1'b1, 1'b0, a, 64'b0, ro, 1'b0, 64'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d, input bit ro = 1'b0);
    cycle(1'b0, 1'b1, 1'b1, a, d, ro, 1'b0, 64'b0);
  endtask

  initial begin
    int n_sent;
    logic [63:0] p1, p2;

    reset            = 1'b1;
    bus.nicEn        = 1'b0;
    bus.nicWrEn      = 1'b0;
    bus.addr         = 2'b00;
    bus.d_in         = '0;
    bus.net_ro       = 1'b0;
    bus.net_si       = 1'b0;
    bus.net_di       = '0;
    bus.net_polarity = 1'b0;
    pol              = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state and status reads.
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 64'b0, 1'b0, 1'b0, 64'b0);
    rd(2'b01);
    chk("rst_so", {63'b0, obs_so}, 64'd0);
    chk("rst_ri", {63'b0, obs_ri}, 64'd1);
    rd(2'b11);
    chk("rst_in_stat", obs_dout, 64'h0);
    idle();
    chk("rst_out_stat", obs_dout, 64'h0);

    // Send with router ready: leaves only when polarity matches bit 0.
    n_sent = sent_q.size();
    wr(2'b10, 64'h8000_0000_0000_00AB, 1'b1);
    repeat (3) idle(1'b1);
    chk("send1_count", 64'(sent_q.size()), 64'(n_sent + 1));
    if (sent_q.size() > 0) chk("send1_data", sent_q[$], 64'h8000_0000_0000_00AB);
    rd(2'b11);
    idle();
    chk("send1_out_stat", obs_dout, 64'h0);

    // Second write while full is dropped.
    n_sent = sent_q.size();
    wr(2'b10, 64'h1);
    repeat (2) idle(1'b0);
    wr(2'b10, 64'h2);
    rd(2'b11);
    idle();
    chk("drop_out_stat", obs_dout, 64'h8000_0000_0000_0000);
    repeat (4) idle(1'b1);
    chk("drop_count", 64'(sent_q.size()), 64'(n_sent + 1));
    if (sent_q.size() > 0) chk("drop_data", sent_q[$], 64'h1);

    // Incoming packet capture and readout.
    p1 = 64'hDEAD_BEEF_0000_0001;
    p2 = 64'h0123_4567_89AB_CDEF;
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 64'b0, 1'b0, 1'b1, p1);
    rd(2'b01);
    chk("cap_ri_low", {63'b0, obs_ri}, 64'd0);
    rd(2'b00);
    chk("cap_in_stat", obs_dout, 64'h8000_0000_0000_0000);
    idle();
    chk("cap_in_data", obs_dout, p1);
    chk("cap_ri_high", {63'b0, obs_ri}, 64'd1);

    // Back-pressure: second packet waits until the slot is read out.
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 64'b0, 1'b0, 1'b1, p1);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 64'b0, 1'b0, 1'b1, p2);
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 64'b0, 1'b0, 1'b1, p2);
    chk("bp_ri_during_read", {63'b0, obs_ri}, 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 64'b0, 1'b0, 1'b1, p2);
    chk("bp_first_pkt", obs_dout, p1);
    chk("bp_ri_after_read", {63'b0, obs_ri}, 64'd1);
    rd(2'b00);
    idle();
    chk("bp_second_pkt", obs_dout, p2);

    // Reset with a packet pending and the router not ready.
    n_sent = sent_q.size();
    wr(2'b10, 64'h5);
    repeat (2) idle(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 64'b0, 1'b0, 1'b0, 64'b0);
    repeat (4) idle(1'b1);
    chk("rstmid_so", {63'b0, obs_so}, 64'd0);
    chk("rstmid_count", 64'(sent_q.size()), 64'(n_sent));

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
            2'($urandom_range(3)), {$urandom, $urandom}, $urandom_range(1),
            $urandom_range(1), {$urandom, $urandom});
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
